// File: rtl/reg_pkg.sv
// Shared types and helpers for the reg_pipe skid-buffer chain.
package reg_pkg;

    // The encoding is chosen so that bit 0 is the main-valid flag and bit 1 is the
    // skid-valid flag. Both stage handshake outputs are then plain flop bits.
    // The combination (m_v=0, s_v=1) is never entered.
    typedef enum logic [1:0] {
        S_EMPTY = 2'b00,
        S_ONE   = 2'b01,
        S_TWO   = 2'b11
    } stage_state_e;

    // Width of a counter that spans 0..2*stages.
    function automatic int CNT_W(input int stages);
        return $clog2(2 * stages + 1);
    endfunction

endpackage

// File: rtl/reg_skid.sv
// Single 2-entry skid-buffer stage. Ready is taken from state only, so chaining
// stages never creates a combinational ready path.
module reg_skid
    import reg_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    stage_state_e     state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_fire, out_fire;

    assign in_ready  = ~state_q[1];
    assign out_valid = state_q[0];
    assign out_data  = main_q;

    // Next-state and data steering. Flush voids both handshakes and keeps the data.
    always_comb begin
        state_d  = state_q;
        main_d   = main_q;
        skid_d   = skid_q;
        in_fire  = in_valid && in_ready;
        out_fire = out_valid && out_ready;
        if (flush) begin
            state_d = S_EMPTY;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (in_fire) begin
                        main_d  = in_data;
                        state_d = S_ONE;
                    end
                end
                S_ONE: begin
                    if (in_fire && out_fire) begin
                        main_d = in_data;
                    end else if (in_fire) begin
                        skid_d  = in_data;
                        state_d = S_TWO;
                    end else if (out_fire) begin
                        state_d = S_EMPTY;
                    end
                end
                S_TWO: begin
                    if (out_fire) begin
                        main_d  = skid_q;
                        state_d = S_ONE;
                    end
                end
                default: state_d = S_EMPTY;
            endcase
        end
    end

    // State and data registers. Reset loads the known data value.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_EMPTY;
            main_q  <= RESET_VALUE;
            skid_q  <= RESET_VALUE;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: rtl/reg_pipe.sv
// Parametrised chain of skid-buffer stages with a valid/ready handshake, flush,
// and a registered count of the beats held in the chain.
module reg_pipe
    import reg_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter int               STAGES      = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [CNT_W(STAGES)-1:0]   count
);

    localparam int CW = CNT_W(STAGES);

    // Index k is the input of stage k. Index STAGES is the chain output.
    logic [WIDTH-1:0] data_c [STAGES+1];
    logic             vld_c  [STAGES+1];
    logic             rdy_c  [STAGES+1];

    logic [CW-1:0]    count_q, count_d;
    logic             in_fire, out_fire;

    assign data_c[0]      = in_data;
    assign vld_c[0]       = in_valid;
    assign rdy_c[STAGES]  = out_ready;
    assign in_ready       = rdy_c[0];
    assign out_data       = data_c[STAGES];
    assign out_valid      = vld_c[STAGES];
    assign count          = count_q;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        reg_skid #(
            .WIDTH       (WIDTH),
            .RESET_VALUE (RESET_VALUE)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .flush     (flush),
            .in_data   (data_c[k]),
            .in_valid  (vld_c[k]),
            .in_ready  (rdy_c[k]),
            .out_data  (data_c[k+1]),
            .out_valid (vld_c[k+1]),
            .out_ready (rdy_c[k+1])
        );
    end

    // The occupancy count follows the chain-level handshakes. Flush empties the chain.
    always_comb begin
        count_d  = count_q;
        in_fire  = in_valid && in_ready;
        out_fire = out_valid && out_ready;
        if (flush) begin
            count_d = '0;
        end else if (in_fire && !out_fire) begin
            count_d = count_q + CW'(1);
        end else if (out_fire && !in_fire) begin
            count_d = count_q - CW'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule
